vc_input_port: RTL

VC_INPUT_PORT -- requirements
Module: vc_input_port

---
 rtl/vc_input_port.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/vc_input_port.sv
// Virtual-channel router input port: one FIFO per VC plus a per-VC
// IDLE/VA/ACTIVE packet FSM driving allocation and switch requests.
module vc_input_port #(
    parameter int unsigned VC_NUM         = 2,
    parameter int unsigned BUFFER_SIZE    = 8,
    parameter int unsigned DEST_ADDR_SIZE = 3,
    parameter int unsigned FLIT_W         = 25
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [FLIT_W-1:0]                   data_i,
    input  logic                                valid_i,
    input  logic [$clog2(VC_NUM)-1:0]           vc_i,
    input  logic [VC_NUM-1:0]                   read_i,
    input  logic [VC_NUM-1:0]                   vc_grant_i,
    output logic [VC_NUM*FLIT_W-1:0]            data_o,
    output logic [VC_NUM*2*DEST_ADDR_SIZE-1:0]  dest_o,
    output logic [VC_NUM-1:0]                   is_empty_o,
    output logic [VC_NUM-1:0]                   is_full_o,
    output logic [VC_NUM-1:0]                   va_req_o,
    output logic [VC_NUM-1:0]                   sa_req_o,
    output logic [VC_NUM-1:0]                   credit_o,
    output logic [VC_NUM-1:0]                   err_o
);

    localparam int unsigned VcW   = $clog2(VC_NUM);
    localparam int unsigned PtrW  = $clog2(BUFFER_SIZE);
    localparam int unsigned CntW  = $clog2(BUFFER_SIZE + 1);
    localparam int unsigned DestW = 2 * DEST_ADDR_SIZE;
    // {x_dest, y_dest} sit directly below the label and vc_id fields
    localparam int unsigned DestLsb = FLIT_W - 2 - VcW - DestW;

    localparam logic [1:0] LblHead     = 2'd0;
    localparam logic [1:0] LblTail     = 2'd2;
    localparam logic [1:0] LblHeadTail = 2'd3;

    typedef enum logic [1:0] {StIdle, StVa, StActive} state_e;

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        logic [FLIT_W-1:0] mem_q [BUFFER_SIZE];
        logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
        logic [CntW-1:0]   cnt_q, cnt_d;
        state_e            state_q, state_d;
        logic [DestW-1:0]  dest_q, dest_d;
        logic              err_q, err_d;
        logic              credit_q;
        logic              first_q, first_d;
        logic [FLIT_W-1:0] front;
        logic [1:0]        label;
        logic              empty, full, push_req, push, pop;

        assign front    = mem_q[rd_ptr_q];
        assign label    = front[FLIT_W-1 -: 2];
        assign empty    = (cnt_q == '0);
        assign full     = (cnt_q == CntW'(BUFFER_SIZE));
        assign pop      = read_i[v] && (state_q == StActive) && !empty;
        assign push_req = valid_i && (vc_i == VcW'(v));
        assign push     = push_req && (!full || pop);

        always_comb begin
            cnt_d = cnt_q;
            if (push && !pop) begin
                cnt_d = cnt_q + CntW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CntW'(1);
            end
        end

        always_comb begin
            state_d = state_q;
            dest_d  = dest_q;
            first_d = first_q;
            err_d   = err_q;
            if (push_req && full && !pop) err_d = 1'b1;
            if (read_i[v] && !pop)        err_d = 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        if (label == LblHead || label == LblHeadTail) begin
                            state_d = StVa;
                            dest_d  = front[DestLsb +: DestW];
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StVa: begin
                    if (vc_grant_i[v]) begin
                        state_d = StActive;
                        first_d = 1'b1;
                    end
                end
                StActive: begin
                    if (pop) begin
                        first_d = 1'b0;
                        if (label == LblTail || label == LblHeadTail) begin
                            state_d = StIdle;
                        end else if (label == LblHead && !first_q) begin
                            // only the packet's own head may leave as HEAD
                            err_d = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                state_q  <= StIdle;
                dest_q   <= '0;
                err_q    <= 1'b0;
                credit_q <= 1'b0;
                first_q  <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
                cnt_q    <= cnt_d;
                state_q  <= state_d;
                dest_q   <= dest_d;
                err_q    <= err_d;
                credit_q <= pop;
                first_q  <= first_d;
            end
        end

        always_ff @(posedge clk) begin
            if (rst && push) mem_q[wr_ptr_q] <= data_i;
        end

        assign data_o[v*FLIT_W +: FLIT_W] = empty ? '0 : front;
        assign dest_o[v*DestW +: DestW]   = dest_q;
        assign is_empty_o[v] = empty;
        assign is_full_o[v]  = full;
        assign va_req_o[v]   = (state_q == StVa);
        assign sa_req_o[v]   = (state_q == StActive) && !empty;
        assign credit_o[v]   = credit_q;
        assign err_o[v]      = err_q;
    end

endmodule
